// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory arbiter.
package dmem_pkg;

  localparam int DMEM_DEPTH    = 512;
  localparam int DMEM_ADDR_LSB = 2;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DMA = 1'b1;

  typedef struct packed {
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } dmem_req_t;

  typedef struct packed {
    logic        rvalid;
    logic [31:0] rdata;
    logic        err;
  } dmem_rsp_t;

endpackage

// File: rtl/dmem_addr_check.sv
// Combinational fault detection: misaligned word access or word index past DEPTH.
module dmem_addr_check
  import dmem_pkg::*;
#(
  parameter int DEPTH = DMEM_DEPTH
) (
  input  logic [31:0] addr,
  output logic        fault
);

  localparam int                WORD_W = 32 - DMEM_ADDR_LSB;
  localparam logic [WORD_W-1:0] LIMIT  = WORD_W'(DEPTH);

  logic [WORD_W-1:0] word_idx;

  assign word_idx = addr[31:DMEM_ADDR_LSB];
  assign fault    = (addr[DMEM_ADDR_LSB-1:0] != '0) || (word_idx >= LIMIT);

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of a single-ported data memory. Port 0 (CPU) has
// priority; a saturating starvation counter lets port 1 (DMA/debug) win a
// conflict after STARVE_LIMIT consecutive denied cycles.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int DEPTH        = DMEM_DEPTH,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        p0_req,
  input  logic        p0_we,
  input  logic [31:0] p0_addr,
  input  logic [31:0] p0_wdata,
  output logic        p0_gnt,
  output logic        p0_rvalid,
  output logic [31:0] p0_rdata,
  output logic        p0_err,
  input  logic        p1_req,
  input  logic        p1_we,
  input  logic [31:0] p1_addr,
  input  logic [31:0] p1_wdata,
  output logic        p1_gnt,
  output logic        p1_rvalid,
  output logic [31:0] p1_rdata,
  output logic        p1_err,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  dmem_req_t  cpu;
  dmem_req_t  dma;
  dmem_req_t  sel;
  logic [1:0] gnt;
  logic [3:0] starve_cnt;
  logic       starved;
  logic       fault;
  dmem_rsp_t  rsp_next;
  dmem_rsp_t  rsp0;
  dmem_rsp_t  rsp1;

  assign cpu = '{req: p0_req, we: p0_we, addr: p0_addr, wdata: p0_wdata};
  assign dma = '{req: p1_req, we: p1_we, addr: p1_addr, wdata: p1_wdata};

  assign starved = (starve_cnt == LIMIT);

  // Grant selection; nothing is granted while reset is held.
  always_comb begin
    gnt = '0;
    if (rst_n) begin
      if (dma.req && (!cpu.req || starved)) begin
        gnt[PORT_DMA] = 1'b1;
      end else if (cpu.req) begin
        gnt[PORT_CPU] = 1'b1;
      end
    end
  end

  assign p0_gnt = gnt[PORT_CPU];
  assign p1_gnt = gnt[PORT_DMA];

  // Port 0 drives the memory bus whenever port 1 is not granted.
  assign sel = gnt[PORT_DMA] ? dma : cpu;

  dmem_addr_check #(
    .DEPTH(DEPTH)
  ) u_addr_check (
    .addr (sel.addr),
    .fault(fault)
  );

  assign mem_addr  = sel.addr;
  assign mem_wdata = sel.wdata;
  assign mem_we    = (|gnt) && sel.req && sel.we && !fault;

  // Response for whichever port is granted this cycle.
  always_comb begin
    rsp_next        = '0;
    rsp_next.rvalid = 1'b1;
    rsp_next.err    = fault;
    rsp_next.rdata  = (fault || sel.we) ? 32'h0 : mem_rdata;
  end

  // Count consecutive denied port-1 cycles; any grant or idle cycle clears it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else if (!dma.req || gnt[PORT_DMA]) begin
      starve_cnt <= '0;
    end else if (starve_cnt < LIMIT) begin
      starve_cnt <= starve_cnt + 4'd1;
    end
  end

  // Registered one-cycle response pulse; the idle port is held at zero.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rsp0 <= '0;
      rsp1 <= '0;
    end else begin
      rsp0 <= gnt[PORT_CPU] ? rsp_next : '0;
      rsp1 <= gnt[PORT_DMA] ? rsp_next : '0;
    end
  end

  assign p0_rvalid = rsp0.rvalid;
  assign p0_rdata  = rsp0.rdata;
  assign p0_err    = rsp0.err;
  assign p1_rvalid = rsp1.rvalid;
  assign p1_rdata  = rsp1.rdata;
  assign p1_err    = rsp1.err;

endmodule
